// File: rtl/bus_port_pkg.sv
// Shared definitions for the bus endpoint FIFO: ID width, destination
// extraction and the RX accept classification.
package bus_port_pkg;

  localparam int ID_W = 8;

  typedef enum logic [1:0] {
    ACC_OK,
    ACC_FULL,
    ACC_MIS
  } rx_acc_e;

  // Packets are passed zero-extended to 64 bits; msb is the packet's top bit index.
  function automatic logic [ID_W-1:0] dest_of(input logic [63:0] pkt, input logic [5:0] msb);
    return pkt[msb -: ID_W];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; simultaneous read and write are legal at any
// fill level, and a read while empty is ignored.
module sync_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr,
  input  logic                   rd,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_rd;
  logic          do_wr;

  // A write into a full FIFO only lands when the head leaves in the same cycle.
  assign do_rd = rd & ~empty;
  assign do_wr = wr & (~full | do_rd);

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign dout  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/bus_port_fifo.sv
// Device-side endpoint for one bus driver port: TX FIFO toward the bus and a
// destination-filtered RX FIFO toward the device, with drop/overflow tracking.
module bus_port_fifo
  import bus_port_pkg::*;
#(
  parameter int              PKG_SZ    = 24,
  parameter int              DEPTH     = 16,
  parameter logic [ID_W-1:0] PORT_ID   = 8'h00,
  parameter logic [ID_W-1:0] BROADCAST = 8'h03
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              host_wr,
  input  logic [PKG_SZ-1:0] host_din,
  output logic              host_full,
  output logic              host_ovf,
  output logic              pndng,
  input  logic              pop,
  output logic [PKG_SZ-1:0] D_pop,
  input  logic              push,
  input  logic [PKG_SZ-1:0] D_push,
  output logic              rx_vld,
  input  logic              rx_rdy,
  output logic [PKG_SZ-1:0] rx_data,
  output logic [7:0]        rx_drop_cnt,
  output logic [7:0]        rx_mis_cnt
);

  logic                   tx_full;
  logic                   tx_empty;
  logic [$clog2(DEPTH):0] tx_count;
  logic                   rx_full;
  logic                   rx_empty;
  logic [$clog2(DEPTH):0] rx_count;
  logic [ID_W-1:0]        dest;
  rx_acc_e                rx_acc;
  logic                   rx_store;
  logic                   unused_counts;

  assign unused_counts = ^{tx_count, rx_count};

  sync_fifo #(.W(PKG_SZ), .DEPTH(DEPTH)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (host_wr),
    .rd    (pop),
    .din   (host_din),
    .dout  (D_pop),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  assign pndng     = ~tx_empty;
  assign host_full = tx_full;

  assign dest = dest_of(64'(D_push), 6'(PKG_SZ - 1));

  // A full RX FIFO still takes the packet when the device drains the head this cycle.
  always_comb begin
    rx_acc = ACC_OK;
    if (dest != PORT_ID && dest != BROADCAST)
      rx_acc = ACC_MIS;
    else if (rx_full && !(rx_rdy && rx_vld))
      rx_acc = ACC_FULL;
  end

  assign rx_store = push && (rx_acc == ACC_OK);

  sync_fifo #(.W(PKG_SZ), .DEPTH(DEPTH)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (rx_store),
    .rd    (rx_rdy),
    .din   (D_push),
    .dout  (rx_data),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  assign rx_vld = ~rx_empty;

  // Overflow is flagged only when a write is actually lost; counters stick at 8'hFF.
  always_ff @(posedge clk) begin
    if (!reset) begin
      host_ovf    <= 1'b0;
      rx_drop_cnt <= 8'd0;
      rx_mis_cnt  <= 8'd0;
    end else begin
      if (host_wr && tx_full && !pop)
        host_ovf <= 1'b1;
      if (push && rx_acc == ACC_FULL && rx_drop_cnt != 8'hFF)
        rx_drop_cnt <= rx_drop_cnt + 8'd1;
      if (push && rx_acc == ACC_MIS && rx_mis_cnt != 8'hFF)
        rx_mis_cnt <= rx_mis_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_bus_port_fifo.sv
// Self-checking bench for bus_port_fifo: directed vector table, hand sequences
// for the full/overflow/saturation corners, and random traffic against a queue model.
module tb_bus_port_fifo;

  localparam int DEPTH = 16;

  logic        clk;
  logic        reset;
  logic        host_wr;
  logic [23:0] host_din;
  logic        host_full;
  logic        host_ovf;
  logic        pndng;
  logic        pop;
  logic [23:0] D_pop;
  logic        push;
  logic [23:0] D_push;
  logic        rx_vld;
  logic        rx_rdy;
  logic [23:0] rx_data;
  logic [7:0]  rx_drop_cnt;
  logic [7:0]  rx_mis_cnt;

  bus_port_fifo #(
    .PKG_SZ    (24),
    .DEPTH     (DEPTH),
    .PORT_ID   (8'h00),
    .BROADCAST (8'h03)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .host_wr     (host_wr),
    .host_din    (host_din),
    .host_full   (host_full),
    .host_ovf    (host_ovf),
    .pndng       (pndng),
    .pop         (pop),
    .D_pop       (D_pop),
    .push        (push),
    .D_push      (D_push),
    .rx_vld      (rx_vld),
    .rx_rdy      (rx_rdy),
    .rx_data     (rx_data),
    .rx_drop_cnt (rx_drop_cnt),
    .rx_mis_cnt  (rx_mis_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        host_wr;
    logic [23:0] host_din;
    logic        pop;
    logic        push;
    logic [23:0] d_push;
    logic        rx_rdy;
    logic        exp_pndng;
    logic [23:0] exp_d_pop;
    logic        exp_rx_vld;
    logic [23:0] exp_rx_data;
    logic [7:0]  exp_mis;
  } vec_t;

  vec_t vecs[12];

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: plain queues and counters following the endpoint rules.
  logic [23:0] tx_q[$];
  logic [23:0] rx_q[$];
  logic        m_ovf;
  int          m_drop;
  int          m_mis;

  function automatic vec_t mk(logic hw, logic [23:0] hd, logic p, logic ps, logic [23:0] pd,
                              logic rr, logic ep, logic [23:0] ed, logic ev, logic [23:0] er,
                              logic [7:0] em);
    vec_t v;
    v.host_wr = hw; v.host_din = hd; v.pop = p; v.push = ps; v.d_push = pd; v.rx_rdy = rr;
    v.exp_pndng = ep; v.exp_d_pop = ed; v.exp_rx_vld = ev; v.exp_rx_data = er; v.exp_mis = em;
    return v;
  endfunction

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkModel(string tag);
    checkOutput({tag, " pndng"},     32'(pndng),       32'(tx_q.size() > 0));
    checkOutput({tag, " D_pop"},     32'(D_pop),       (tx_q.size() > 0) ? 32'(tx_q[0]) : 32'd0);
    checkOutput({tag, " host_full"}, 32'(host_full),   32'(tx_q.size() == DEPTH));
    checkOutput({tag, " host_ovf"},  32'(host_ovf),    32'(m_ovf));
    checkOutput({tag, " rx_vld"},    32'(rx_vld),      32'(rx_q.size() > 0));
    checkOutput({tag, " rx_data"},   32'(rx_data),     (rx_q.size() > 0) ? 32'(rx_q[0]) : 32'd0);
    checkOutput({tag, " drop_cnt"},  32'(rx_drop_cnt), 32'(m_drop));
    checkOutput({tag, " mis_cnt"},   32'(rx_mis_cnt),  32'(m_mis));
  endtask

  // Drive one cycle of inputs, advance the model, and sample #1 after the edge.
  task automatic applyStimulus(logic hw, logic [23:0] hd, logic p, logic ps, logic [23:0] pd,
                               logic rr, string tag);
    int   ts;
    int   rs;
    logic do_pop;
    logic do_wr;
    logic do_rd;
    logic store;
    logic [7:0] dst;
    host_wr = hw; host_din = hd; pop = p; push = ps; D_push = pd; rx_rdy = rr;
    ts     = tx_q.size();
    do_pop = p && (ts > 0);
    do_wr  = hw && ((ts < DEPTH) || do_pop);
    if (hw && !do_wr) m_ovf = 1'b1;
    if (do_pop) void'(tx_q.pop_front());
    if (do_wr) tx_q.push_back(hd);
    rs    = rx_q.size();
    do_rd = rr && (rs > 0);
    store = 1'b0;
    if (ps) begin
      dst = pd[23:16];
      if (dst != 8'h00 && dst != 8'h03) begin
        if (m_mis < 255) m_mis++;
      end else if (rs < DEPTH || do_rd) begin
        store = 1'b1;
      end else if (m_drop < 255) begin
        m_drop++;
      end
    end
    if (do_rd) void'(rx_q.pop_front());
    if (store) rx_q.push_back(pd);
    @(posedge clk);
    #1;
    checkModel(tag);
  endtask

  task automatic idle(int n, string tag);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 24'h0, 1'b0, 1'b0, 24'h0, 1'b0, tag);
  endtask

  task automatic doReset();
    reset = 1'b0;
    host_wr = 1'b0; host_din = '0; pop = 1'b0; push = 1'b0; D_push = '0; rx_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    tx_q.delete();
    rx_q.delete();
    m_ovf = 1'b0; m_drop = 0; m_mis = 0;
  endtask

  task automatic checkAllZero(string tag);
    checkOutput({tag, " pndng"},     32'(pndng),       32'd0);
    checkOutput({tag, " D_pop"},     32'(D_pop),       32'd0);
    checkOutput({tag, " rx_vld"},    32'(rx_vld),      32'd0);
    checkOutput({tag, " rx_data"},   32'(rx_data),     32'd0);
    checkOutput({tag, " host_full"}, 32'(host_full),   32'd0);
    checkOutput({tag, " host_ovf"},  32'(host_ovf),    32'd0);
    checkOutput({tag, " drop_cnt"},  32'(rx_drop_cnt), 32'd0);
    checkOutput({tag, " mis_cnt"},   32'(rx_mis_cnt),  32'd0);
  endtask

  initial begin
    // Directed table: TX ordering, empty pop, RX filtering and drain.
    vecs[0]  = mk(1'b1, 24'h01ABCD, 1'b0, 1'b0, 24'h0, 1'b0, 1'b1, 24'h01ABCD, 1'b0, 24'h0, 8'd0);
    vecs[1]  = mk(1'b1, 24'h021234, 1'b0, 1'b0, 24'h0, 1'b0, 1'b1, 24'h01ABCD, 1'b0, 24'h0, 8'd0);
    vecs[2]  = mk(1'b0, 24'h0, 1'b1, 1'b0, 24'h0, 1'b0, 1'b1, 24'h021234, 1'b0, 24'h0, 8'd0);
    vecs[3]  = mk(1'b0, 24'h0, 1'b1, 1'b0, 24'h0, 1'b0, 1'b0, 24'h0, 1'b0, 24'h0, 8'd0);
    vecs[4]  = mk(1'b0, 24'h0, 1'b1, 1'b0, 24'h0, 1'b0, 1'b0, 24'h0, 1'b0, 24'h0, 8'd0);
    vecs[5]  = mk(1'b0, 24'h0, 1'b0, 1'b1, 24'h000001, 1'b0, 1'b0, 24'h0, 1'b1, 24'h000001, 8'd0);
    vecs[6]  = mk(1'b0, 24'h0, 1'b0, 1'b1, 24'h030002, 1'b0, 1'b0, 24'h0, 1'b1, 24'h000001, 8'd0);
    vecs[7]  = mk(1'b0, 24'h0, 1'b0, 1'b1, 24'h050003, 1'b0, 1'b0, 24'h0, 1'b1, 24'h000001, 8'd1);
    vecs[8]  = mk(1'b0, 24'h0, 1'b0, 1'b0, 24'h0, 1'b1, 1'b0, 24'h0, 1'b1, 24'h030002, 8'd1);
    vecs[9]  = mk(1'b0, 24'h0, 1'b0, 1'b0, 24'h0, 1'b1, 1'b0, 24'h0, 1'b0, 24'h0, 8'd1);
    vecs[10] = mk(1'b1, 24'h0C0FFE, 1'b1, 1'b0, 24'h0, 1'b1, 1'b1, 24'h0C0FFE, 1'b0, 24'h0, 8'd1);
    vecs[11] = mk(1'b0, 24'h0, 1'b1, 1'b0, 24'h0, 1'b0, 1'b0, 24'h0, 1'b0, 24'h0, 8'd1);

    // Reset state and quiet idle period.
    doReset();
    checkAllZero("reset");
    idle(5, "idle");

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].host_wr, vecs[i].host_din, vecs[i].pop, vecs[i].push,
                    vecs[i].d_push, vecs[i].rx_rdy, $sformatf("vec%0d", i));
      checkOutput($sformatf("vec%0d pndng", i),   32'(pndng),      32'(vecs[i].exp_pndng));
      checkOutput($sformatf("vec%0d D_pop", i),   32'(D_pop),      32'(vecs[i].exp_d_pop));
      checkOutput($sformatf("vec%0d rx_vld", i),  32'(rx_vld),     32'(vecs[i].exp_rx_vld));
      checkOutput($sformatf("vec%0d rx_data", i), 32'(rx_data),    32'(vecs[i].exp_rx_data));
      checkOutput($sformatf("vec%0d mis", i),     32'(rx_mis_cnt), 32'(vecs[i].exp_mis));
    end

    // TX fill, overflow with pop=0, then drain in order without the lost packet.
    doReset();
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 24'(256 + i), 1'b0, 1'b0, 24'h0, 1'b0, "fill");
    checkOutput("fill full", 32'(host_full), 32'd1);
    checkOutput("fill ovf", 32'(host_ovf), 32'd0);
    applyStimulus(1'b1, 24'hBADBAD, 1'b0, 1'b0, 24'h0, 1'b0, "ovf");
    checkOutput("ovf flag", 32'(host_ovf), 32'd1);
    checkOutput("ovf full", 32'(host_full), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      checkOutput($sformatf("drain%0d D_pop", i), 32'(D_pop), 32'(256 + i));
      applyStimulus(1'b0, 24'h0, 1'b1, 1'b0, 24'h0, 1'b0, "drain");
    end
    checkOutput("drain pndng", 32'(pndng), 32'd0);
    checkOutput("drain ovf sticky", 32'(host_ovf), 32'd1);

    // Write and pop together while full: both happen, no overflow.
    doReset();
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 24'(512 + i), 1'b0, 1'b0, 24'h0, 1'b0, "fill2");
    applyStimulus(1'b1, 24'h0F00D0, 1'b1, 1'b0, 24'h0, 1'b0, "wrpop");
    checkOutput("wrpop ovf", 32'(host_ovf), 32'd0);
    checkOutput("wrpop full", 32'(host_full), 32'd1);
    checkOutput("wrpop D_pop", 32'(D_pop), 32'(513));

    // RX overfill with rx_rdy=0, ordered drain, then mis-counter saturation.
    doReset();
    for (int i = 0; i < DEPTH + 2; i++) applyStimulus(1'b0, 24'h0, 1'b0, 1'b1, 24'(i), 1'b0, "rxfill");
    checkOutput("rxfill drop", 32'(rx_drop_cnt), 32'd2);
    for (int i = 0; i < DEPTH; i++) begin
      checkOutput($sformatf("rxdrain%0d data", i), 32'(rx_data), 32'(i));
      applyStimulus(1'b0, 24'h0, 1'b0, 1'b0, 24'h0, 1'b1, "rxdrain");
    end
    checkOutput("rxdrain vld", 32'(rx_vld), 32'd0);
    for (int i = 0; i < 300; i++) applyStimulus(1'b0, 24'h0, 1'b0, 1'b1, 24'h420000 | 24'(i), 1'b0, "foreign");
    checkOutput("mis saturate", 32'(rx_mis_cnt), 32'hFF);

    // Mid-traffic reset discards everything.
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 24'(768 + i), 1'b0, 1'b0, 24'h0, 1'b0, "mtx");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 24'h0, 1'b0, 1'b1, 24'h030000 | 24'(i), 1'b0, "mrx");
    applyStimulus(1'b1, 24'h0, 1'b0, 1'b1, 24'h770000, 1'b0, "mmis");
    doReset();
    checkAllZero("midreset");
    applyStimulus(1'b1, 24'h0A0A0A, 1'b0, 1'b1, 24'h000777, 1'b0, "post");
    checkOutput("post D_pop", 32'(D_pop), 32'h0A0A0A);
    checkOutput("post rx_data", 32'(rx_data), 32'h000777);

    // Random traffic: write-heavy phase then drain-heavy phase.
    doReset();
    for (int i = 0; i < 1600; i++) begin
      logic hw, p, ps, rr;
      logic [7:0] dst;
      int r;
      hw = ($urandom_range(0, 99) < ((i < 800) ? 70 : 30));
      p  = ($urandom_range(0, 99) < ((i < 800) ? 30 : 70));
      ps = ($urandom_range(0, 99) < 60);
      rr = ($urandom_range(0, 99) < ((i < 800) ? 25 : 75));
      r  = $urandom_range(0, 3);
      dst = (r == 0) ? 8'h00 : (r == 1) ? 8'h03 : 8'($urandom);
      applyStimulus(hw, 24'($urandom), p, ps, {dst, 16'($urandom)}, rr, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
